// File: rtl/cube_infer_ctrl.sv
// rtl/cube_infer_ctrl.sv - candidate cube-state evaluation sequencer
// Walks candidate memory, feeds each state to the network and keeps the best signed score.
module cube_infer_ctrl #(
   parameter int NUM_CAND = 18,
   parameter int ADDR_W   = 5,
   parameter int SCORE_W  = 16,
   parameter int TIMEOUT  = 1023
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic               o_mem_rd,
   output logic [ADDR_W-1:0]  o_mem_addr,
   input  logic [119:0]       i_mem_data,
   output logic               o_buf_load,
   output logic [119:0]       o_buf_d,
   output logic               o_net_start,
   input  logic               i_net_done,
   input  logic [SCORE_W-1:0] i_net_score,
   output logic [ADDR_W-1:0]  o_best_idx,
   output logic [SCORE_W-1:0] o_best_score
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_RUN, S_WAIT, S_FINISH} state_t;

   state_t              r_state;
   logic [WD_W-1:0]     r_wd;
   logic                r_busy, r_done, r_err, r_mem_rd, r_buf_load, r_net_start;
   logic [ADDR_W-1:0]   r_mem_addr, r_best_idx;
   logic [SCORE_W-1:0]  r_best_score;

   logic w_last, w_timeout, w_better;

   // r_mem_addr doubles as the running candidate index
   assign w_last    = (r_mem_addr == ADDR_W'(NUM_CAND - 1));
   assign w_timeout = (r_wd == WD_W'(TIMEOUT - 1));
   assign w_better  = ($signed(i_net_score) > $signed(r_best_score));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_wd         <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_mem_rd     <= 1'b0;
         r_buf_load   <= 1'b0;
         r_net_start  <= 1'b0;
         r_mem_addr   <= '0;
         r_best_idx   <= '0;
         r_best_score <= '0;
      end else begin
         r_mem_rd    <= 1'b0;
         r_buf_load  <= 1'b0;
         r_net_start <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state      <= S_READ;
                  r_mem_addr   <= '0;
                  r_best_score <= {1'b1, {(SCORE_W-1){1'b0}}};
                  r_best_idx   <= '0;
                  r_err        <= 1'b0;
                  r_busy       <= 1'b1;
                  r_mem_rd     <= 1'b1;
               end
            end
            S_READ: begin
               r_state    <= S_LOAD;
               r_buf_load <= 1'b1;
            end
            S_LOAD: begin
               r_state     <= S_RUN;
               r_net_start <= 1'b1;
            end
            S_RUN: begin
               r_state <= S_WAIT;
               r_wd    <= '0;
            end
            S_WAIT: begin
               r_wd <= r_wd + WD_W'(1);
               // a late net_done coinciding with the timeout still counts as a result
               if (i_net_done || w_timeout) begin
                  if (i_net_done && w_better) begin
                     r_best_score <= i_net_score;
                     r_best_idx   <= r_mem_addr;
                  end
                  if (!i_net_done)
                     r_err <= 1'b1;
                  if (w_last) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_READ;
                     r_mem_addr <= r_mem_addr + ADDR_W'(1);
                     r_mem_rd   <= 1'b1;
                  end
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_mem_rd     = r_mem_rd;
   assign o_mem_addr   = r_mem_addr;
   assign o_buf_load   = r_buf_load;
   assign o_buf_d      = i_mem_data;
   assign o_net_start  = r_net_start;
   assign o_best_idx   = r_best_idx;
   assign o_best_score = r_best_score;

endmodule

// File: tb/tb_cube_infer_ctrl.sv
// tb/tb_cube_infer_ctrl.sv - scoreboard bench for cube_infer_ctrl
module tb_cube_infer_ctrl;

   localparam int NC = 4;
   localparam int AW = 5;
   localparam int SW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [119:0]  mem_data = '1;
   logic          net_done = 1'b0;
   logic [SW-1:0] net_score = '0;

   logic          o_busy, o_done, o_err, o_mem_rd, o_buf_load, o_net_start;
   logic [AW-1:0] o_mem_addr, o_best_idx;
   logic [119:0]  o_buf_d;
   logic [SW-1:0] o_best_score;

   always #5 clk = ~clk;

   cube_infer_ctrl #(.NUM_CAND(NC), .ADDR_W(AW), .SCORE_W(SW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(mem_data),
      .o_buf_load(o_buf_load), .o_buf_d(o_buf_d), .o_net_start(o_net_start),
      .i_net_done(net_done), .i_net_score(net_score),
      .o_best_idx(o_best_idx), .o_best_score(o_best_score)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] idx;
      logic [SW-1:0] score;
      logic          err;
      int            cycles;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;

   logic [119:0]  mem    [NC];
   logic [SW-1:0] scores [NC];
   int            lat    [NC];
   bit            hang   [NC];
   bit            spurious = 1'b0;

   // memory and network responder, drives on the falling edge
   bit            prev_rd = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   bit            pend = 1'b0;
   int            cnt = 0;
   int            cur = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0; prev_rd = 1'b0; net_done = 1'b0; mem_data = '1;
      end else begin
         mem_data = prev_rd ? mem[int'(prev_addr)] : '1;
         prev_rd = o_mem_rd;
         prev_addr = o_mem_addr;
         net_done = 1'b0;
         net_score = '0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               pend = 1'b0; net_done = 1'b1; net_score = scores[cur];
            end
         end
         if (o_net_start) begin
            cur = int'(o_mem_addr);
            if (!hang[cur]) begin
               pend = 1'b1; cnt = lat[cur];
            end
         end
         if (spurious && (o_mem_rd || o_buf_load)) begin
            net_done = 1'b1; net_score = 16'h7fff;
         end
      end
   end

   // monitor: protocol checks every cycle, result checks on done
   int busy_cyc = 0;
   bit prev_bl = 1'b0;
   bit prev_done = 1'b0;
   int exp_addr = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         busy_cyc = 0; prev_bl = 1'b0; prev_done = 1'b0; exp_addr = 0;
      end else begin
         if (o_busy) busy_cyc++;
         if (prev_done) chk("done_width", 128'(o_done), 128'(0));
         if ((int'(o_mem_rd) + int'(o_buf_load) + int'(o_net_start)) > 1)
            chk("strobe_onehot", {o_mem_rd, o_buf_load, o_net_start}, 128'(0));
         if (o_mem_rd) begin
            chk("mem_addr", 128'(o_mem_addr), 128'(exp_addr));
            exp_addr++;
         end
         if (o_buf_load) chk("buf_d", 128'(o_buf_d), 128'(mem[int'(o_mem_addr) % NC]));
         if (o_net_start) chk("net_start_after_load", 128'(prev_bl), 128'(1));
         if (o_done) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
               e_mon = sb.pop_front();
               chk("best_idx",   128'(o_best_idx),   128'(e_mon.idx));
               chk("best_score", 128'(o_best_score), 128'(e_mon.score));
               chk("err",        128'(o_err),        128'(e_mon.err));
               chk("run_cycles", 128'(busy_cyc),     128'(e_mon.cycles));
            end
            done_cnt++;
         end
         if (!o_busy) begin
            busy_cyc = 0; exp_addr = 0;
         end
         prev_bl = o_buf_load;
         prev_done = o_done;
      end
   end

   task automatic fill_mem();
      for (int i = 0; i < NC; i++)
         mem[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic do_run(input exp_t e, input bit glitch);
      int d0;
      sb.push_back(e);
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 300 && done_cnt == d0; i++) begin
         start = glitch && (i == 5 || i == 12);
         @(negedge clk);
      end
      start = 1'b0;
      if (done_cnt == d0) begin
         vectors++; miscompares++;
         $display("FAIL run_timeout: got no done expected done within 300 cycles");
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_zero(input string name);
      chk(name, {o_busy, o_done, o_err, o_mem_rd, o_buf_load, o_net_start,
                 o_mem_addr, o_best_idx, o_best_score}, 128'(0));
   endtask

   initial begin
      int k;
      hang = '{0, 0, 0, 0};
      fill_mem();
      repeat (3) @(negedge clk);
      chk_zero("reset_state");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      scores = '{16'h0005, 16'hfffd, 16'h000c, 16'h000c};
      lat = '{2, 2, 2, 2};
      do_run('{5'd2, 16'h000c, 1'b0, 21}, 1'b0);

      fill_mem();
      scores = '{16'hff9c, 16'hfff9, 16'hffce, 16'hfff9};
      lat = '{3, 3, 3, 8};
      do_run('{5'd1, 16'hfff9, 1'b0, 30}, 1'b0);

      fill_mem();
      scores = '{16'h0003, 16'h0063, 16'h0007, 16'hfffe};
      lat = '{1, 1, 1, 1};
      hang = '{0, 1, 0, 0};
      do_run('{5'd2, 16'h0007, 1'b1, 24}, 1'b0);

      fill_mem();
      scores = '{16'h0005, 16'hfffd, 16'h000c, 16'h000c};
      lat = '{2, 2, 2, 2};
      hang = '{0, 0, 0, 0};
      spurious = 1'b1;
      do_run('{5'd2, 16'h000c, 1'b0, 21}, 1'b1);
      spurious = 1'b0;

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      k = 0;
      while (!(o_net_start && o_mem_addr == 5'd2) && k < 200) begin
         @(negedge clk); #2; k++;
      end
      if (k >= 200) begin
         vectors++; miscompares++;
         $display("FAIL reset_wait: got no net_start for candidate 2 expected one");
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrun_reset");
      @(negedge clk);
      chk_zero("midrun_reset_hold");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_run('{5'd2, 16'h000c, 1'b0, 21}, 1'b0);

      hang = '{1, 1, 1, 1};
      do_run('{5'd0, 16'h8000, 1'b1, 45}, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cube_infer_ctrl.md
Name: cube_infer_ctrl

Overview:
- Sequences cube-state evaluation for the solver datapath.
- For each of NUM_CAND candidate states it:
  - reads a packed 120-bit cube state from the candidate state memory;
  - loads it into the cube data buffer;
  - starts the network and waits for its score.
- Tracks the best-scoring candidate and reports it with a one-cycle done pulse.
- Sits between the candidate generator memory, cube_data_buffer and the network core.

Parameters:
- NUM_CAND, 18, number of candidates evaluated per run (1..2**ADDR_W).
- ADDR_W, 5, candidate memory address width.
- SCORE_W, 16, signed network score width.
- TIMEOUT, 1023, maximum cycles waited for net_done per candidate (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until FINISH completes.
- done  out  1  one-cycle pulse in the FINISH state.
- err  out  1  high if any candidate timed out in the last run.
- mem_rd  out  1  candidate memory read strobe.
- mem_addr  out  ADDR_W  candidate index being read.
- mem_data  in  120  packed cube state, valid exactly one cycle after mem_rd.
- buf_load  out  1  load strobe to cube_data_buffer.
- buf_d  out  120  state to buffer; combinational copy of mem_data.
- net_start  out  1  one-cycle network start pulse.
- net_done  in  1  network completion pulse.
- net_score  in  SCORE_W  signed score, valid while net_done is high.
- best_idx  out  ADDR_W  index of best candidate.
- best_score  out  SCORE_W  signed best score.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - busy, done, err, mem_rd, buf_load, net_start = 0.
  - mem_addr, best_idx = 0; best_score = 0; watchdog = 0.
- States: IDLE, READ, LOAD, RUN, WAIT, FINISH.
- IDLE:
  - start=1 → READ.
  - Also: idx=0, best_score=most negative value (1 followed by zeros), best_idx=0, err=0, busy=1.
- READ:
  - mem_rd=1, mem_addr=idx.
  - → LOAD next cycle.
- LOAD:
  - buf_load=1; buf_d carries mem_data this cycle.
  - → RUN.
- RUN:
  - net_start=1 for exactly one cycle.
  - watchdog cleared.
  - → WAIT.
- WAIT:
  - watchdog increments each cycle.
  - On net_done=1:
    - If net_score > best_score (signed, strict), update best_score=net_score and best_idx=idx. Ties keep the earlier index.
    - If idx==NUM_CAND-1 → FINISH; else idx+1 → READ.
  - If watchdog reaches TIMEOUT without net_done:
    - err=1 (sticky until next accepted start).
    - Candidate skipped, no score update; advance exactly as above.
  - net_done and timeout in the same cycle: net_done wins, no err.
- FINISH:
  - done=1 for one cycle, busy=0 at the same edge.
  - → IDLE.
  - best_idx/best_score/err hold until the next accepted start.
- Per-candidate latency: 3 cycles + network latency (cycles from net_start to net_done).
- Total run length, no timeouts: sum over candidates of (3 + L_i), + 1 FINISH cycle.
- Ignored inputs:
  - start outside IDLE is ignored.
  - net_done outside WAIT is ignored.
- All outputs registered except buf_d.
- Only one of mem_rd/buf_load/net_start is high in any cycle.
- rst_n asserted mid-run: immediate return to reset values. No done pulse, no partial result retained.
- If all candidates time out: best_score remains most negative, best_idx=0, err=1.

Test Plan:
- Reset, then start with NUM_CAND=4, network returning scores 5, -3, 12, 12 after 2 cycles each → done after 4×5+1 cycles, best_idx=2, best_score=12, err=0.
- Scores all negative (-100, -7, -50, …) → best_score=-7 at its index; confirms signed compare and most-negative init.
- Network never asserts net_done for candidate 1, TIMEOUT=8 → candidate 1 skipped after 8 WAIT cycles, err=1, run completes, best chosen from remaining candidates.
- Pulse start during busy and net_done during READ/LOAD → no restart, no score update; run result identical to an unperturbed run.
- Assert rst_n low during WAIT of candidate 2 → all outputs zero immediately; a new start runs from idx 0 normally.
- Protocol check across a run: mem_addr increments 0..NUM_CAND-1; buf_d equals memory contents in buf_load cycles; each net_start is followed by a buf_load exactly one cycle earlier; done is exactly one cycle wide.
